// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the IF/MEM memory port arbiter.
// Holds the arbiter state encoding, the grant identifier used for
// round-robin alternation, and the width of the bus timeout counter.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_STATE_W = 2;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE   = 2'b00,
        ARB_IF_ACC = 2'b01,
        ARB_D_ACC  = 2'b10
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/acknowledge memory bus between the arbiter
// (master) and the external memory wrapper (slave).
//   mem_req   master->slave  access request, held until ack or abort
//   mem_we    master->slave  1 = write
//   mem_addr  master->slave  access address
//   mem_sel   master->slave  byte enables
//   mem_wdata master->slave  write data
//   mem_rdata slave->master  read data, valid with mem_ack
//   mem_ack   slave->master  one-cycle completion pulse
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory bus between instruction
// fetch (IF) and load/store (D). One access at a time; D wins a tie unless
// D had the previous grant. A counter aborts an access that sees no mem_ack
// within TIMEOUT cycles, returning zero with bus_err.
// Optional build macro ARB_IF_BSWAP_EN: fetched words are byte-reversed
// into if_inst (DATA_W must be 32); data path unaffected.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_ce/if_addr       fetch request (held until if_ready)
//   if_inst/if_ready    registered fetch result and one-cycle valid pulse
//   d_ce/d_we/d_addr/d_sel/d_wdata   load/store request (held until d_ready)
//   d_rdata/d_ready     registered load result and one-cycle done pulse
//   stallreq            combinational stall toward the pipeline control
//   bus_err             one-cycle pulse on timeout abort (with ready)
//   bus                 memory bus, master side
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ce,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_inst,
    output logic                  if_ready,
    input  logic                  d_ce,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_sel,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready,
    output logic                  stallreq,
    output logic                  bus_err,
    mem_port_arbiter_if.master    bus
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    grant_t            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;

    logic              if_pend_c, d_pend_c, owner_ce_c, expire_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [DATA_W-1:0] fetch_data_c;

    // A requester still showing ce in its ready cycle is the tail of the
    // request just served, not a new one.
    assign if_pend_c = if_ce & ~if_ready_q;
    assign d_pend_c  = d_ce & ~d_ready_q;
    assign stallreq  = if_pend_c | d_pend_c;

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign expire_c  = (cnt_inc_c == CNT_W'(TIMEOUT));

`ifdef ARB_IF_BSWAP_EN
    // Little-endian ROM images: reverse byte order on the fetch path only.
    assign fetch_data_c = {<<8{bus.mem_rdata}};
`else
    assign fetch_data_c = bus.mem_rdata;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        if_inst_d  = if_inst_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        bus_err_d  = 1'b0;
        owner_ce_c = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (d_pend_c && (!if_pend_c || last_q == GRANT_IF)) begin
                    state_d = ARB_D_ACC;
                    req_d   = 1'b1;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    sel_d   = d_sel;
                    wdata_d = d_wdata;
                    last_d  = GRANT_D;
                end else if (if_pend_c) begin
                    state_d = ARB_IF_ACC;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    sel_d   = '1;
                    wdata_d = '0;
                    last_d  = GRANT_IF;
                end
            end

            ARB_IF_ACC, ARB_D_ACC: begin
                owner_ce_c = (state_q == ARB_IF_ACC) ? if_ce : d_ce;
                if (bus.mem_ack || expire_c) begin
                    state_d = ARB_IDLE;
                    req_d   = 1'b0;
                    // An abandoned request completes silently on the bus.
                    if (owner_ce_c) begin
                        bus_err_d = ~bus.mem_ack;
                        if (state_q == ARB_IF_ACC) begin
                            if_ready_d = 1'b1;
                            if_inst_d  = bus.mem_ack ? fetch_data_c : '0;
                        end else begin
                            d_ready_d = 1'b1;
                            if (!bus.mem_ack) begin
                                d_rdata_d = '0;
                            end else if (!we_q) begin
                                d_rdata_d = bus.mem_rdata;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_q     <= GRANT_IF;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            if_inst_q  <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            if_inst_q  <= if_inst_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign if_inst       = if_inst_q;
    assign if_ready      = if_ready_q;
    assign d_rdata       = d_rdata_q;
    assign d_ready       = d_ready_q;
    assign bus_err       = bus_err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and bus responder, all checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 15;

`ifdef ARB_IF_BSWAP_EN
    localparam logic [31:0] T1_INST = 32'h0011_0134;
    localparam logic [31:0] T6_INST = 32'h2222_1111;
    localparam logic [31:0] T7_INST = 32'h3401_1100;
`else
    localparam logic [31:0] T1_INST = 32'h3401_1100;
    localparam logic [31:0] T6_INST = 32'h1111_2222;
    localparam logic [31:0] T7_INST = 32'h0011_0134;
`endif

    logic          clk;
    logic          rst;
    logic          if_ce, d_ce, d_we;
    logic [31:0]   if_addr, d_addr, d_wdata;
    logic [3:0]    d_sel;
    logic [31:0]   if_inst, d_rdata;
    logic          if_ready, d_ready, stallreq, bus_err;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst), .if_ready(if_ready),
        .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .stallreq(stallreq), .bus_err(bus_err),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] w);
        logic [31:0] r;
`ifdef ARB_IF_BSWAP_EN
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    // ---------------- bus responder ----------------
    int          ack_delay = 0;       // -1: never acknowledge
    logic [31:0] ack_rdata = '0;
    bit          rnd_mode  = 0;
    int          late_req  = 0;
    int          late_done = 0;
    int          req_cycles = 0;
    int          cur_delay  = 0;
    logic        resp_ack;

    always @(negedge clk) begin
        resp_ack = 1'b0;
        if (bus_if.mem_req === 1'b1) begin
            req_cycles++;
            if (req_cycles == 1)
                cur_delay = rnd_mode ? (($urandom_range(11) == 0) ? -1 : int'($urandom_range(5)))
                                     : ack_delay;
            if (cur_delay >= 0 && req_cycles == cur_delay + 1) begin
                resp_ack = 1'b1;
                bus_if.mem_rdata = rnd_mode ? $urandom : ack_rdata;
            end
        end else begin
            req_cycles = 0;
            if (late_req != late_done) begin
                late_done++;
                resp_ack = 1'b1;
                bus_if.mem_rdata = $urandom;
            end else if (rnd_mode && $urandom_range(7) == 0) begin
                resp_ack = 1'b1;
                bus_if.mem_rdata = $urandom;
            end
        end
        bus_if.mem_ack = resp_ack;
    end

    // ---------------- reference model ----------------
    // One outstanding transaction at most; its age is the number of cycles
    // it has been on the bus.
    bit          m_busy, m_is_d, m_we, m_last_d;
    int          m_age;
    logic        exp_req, exp_we, exp_if_ready, exp_d_ready, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_if_inst, exp_d_rdata;
    logic [3:0]  exp_sel;

    always @(posedge clk) begin
        bit want_if, want_d, owner_ce, ack;
        if (rst) begin
            m_busy = 0; m_last_d = 0; m_age = 0; m_we = 0; m_is_d = 0;
            exp_req = 0; exp_we = 0; exp_addr = '0; exp_sel = '0; exp_wdata = '0;
            exp_if_inst = '0; exp_d_rdata = '0;
            exp_if_ready = 0; exp_d_ready = 0; exp_err = 0;
        end else begin
            want_if = if_ce && !exp_if_ready;
            want_d  = d_ce && !exp_d_ready;
            exp_if_ready = 0; exp_d_ready = 0; exp_err = 0;
            if (!m_busy) begin
                if (want_d && !(want_if && m_last_d)) begin
                    m_busy = 1; m_is_d = 1; m_we = d_we; m_age = 0; m_last_d = 1;
                    exp_req = 1; exp_we = d_we; exp_addr = d_addr; exp_sel = d_sel; exp_wdata = d_wdata;
                end else if (want_if) begin
                    m_busy = 1; m_is_d = 0; m_we = 0; m_age = 0; m_last_d = 0;
                    exp_req = 1; exp_we = 0; exp_addr = if_addr; exp_sel = 4'hF;
                end
            end else begin
                m_age++;
                ack = (bus_if.mem_ack === 1'b1);
                if (ack || m_age == TMO) begin
                    owner_ce = m_is_d ? d_ce : if_ce;
                    if (owner_ce) begin
                        exp_err = !ack;
                        if (!m_is_d) begin
                            exp_if_ready = 1;
                            exp_if_inst  = ack ? fetch_word(bus_if.mem_rdata) : 32'h0;
                        end else begin
                            exp_d_ready = 1;
                            if (!ack) exp_d_rdata = 32'h0;
                            else if (!m_we) exp_d_rdata = bus_if.mem_rdata;
                        end
                    end
                    m_busy = 0;
                    exp_req = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("if_ready", if_ready, exp_if_ready);
            check("d_ready", d_ready, exp_d_ready);
            check("bus_err", bus_err, exp_err);
            check("if_inst", if_inst, exp_if_inst);
            check("d_rdata", d_rdata, exp_d_rdata);
            check("mem_req", bus_if.mem_req, exp_req);
            check("stallreq", stallreq, (if_ce & ~exp_if_ready) | (d_ce & ~exp_d_ready));
            if (exp_req) begin
                check("mem_we", bus_if.mem_we, exp_we);
                check("mem_addr", bus_if.mem_addr, exp_addr);
                check("mem_sel", bus_if.mem_sel, exp_sel);
                if (exp_we) check("mem_wdata", bus_if.mem_wdata, exp_wdata);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_d, input int limit, output int lat, output bit seen);
        seen = 0;
        lat  = 0;
        while (!seen && lat < limit) begin
            tick();
            lat++;
            if (is_d ? d_ready : if_ready) seen = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hi, ng, stall_hi, rdy_cnt, err_cnt;
        bit seen, prev_req, stall_at_rdy, err_at_rdy;
        logic [31:0] saw_addr, rd_at_rdy;
        logic [3:0]  saw_sel;
        logic [31:0] g_addr [4];
        logic        g_we   [4];
        logic [31:0] g_wdata[4];

        rst = 1; if_ce = 0; d_ce = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
        tick(); tick();
        rst = 0;
        chk_on = 1;
        check("rst_mem_req", bus_if.mem_req, 1'b0);
        check("rst_mem_addr", bus_if.mem_addr, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_stallreq", stallreq, 1'b0);

        // T1: fetch of 0x10, ack on the third bus cycle
        ack_delay = 2; ack_rdata = 32'h3401_1100;
        if_ce = 1; if_addr = 32'h10;
        seen = 0; lat = 0; stall_hi = 0; saw_addr = '0; saw_sel = '0; stall_at_rdy = 1;
        while (!seen && lat < 30) begin
            tick(); lat++;
            if (bus_if.mem_req && saw_sel == 4'h0) begin
                saw_addr = bus_if.mem_addr; saw_sel = bus_if.mem_sel;
            end
            if (if_ready) begin seen = 1; stall_at_rdy = stallreq; end
            else if (stallreq) stall_hi++;
        end
        check("t1_seen", seen, 1'b1);
        check("t1_latency", lat, 4);
        check("t1_addr", saw_addr, 32'h10);
        check("t1_sel", saw_sel, 4'hF);
        check("t1_inst", if_inst, T1_INST);
        check("t1_stall_hi", stall_hi, 3);
        check("t1_stall_at_ready", stall_at_rdy, 1'b0);
        if_ce = 0; tick();

        // T2: both requesters held -> D, IF, D, IF
        ack_delay = 1;
        if_ce = 1; if_addr = 32'h100;
        d_ce = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_sel = 4'hF;
        ng = 0; prev_req = 0; lat = 0;
        while (ng < 4 && lat < 100) begin
            tick(); lat++;
            if (bus_if.mem_req && !prev_req) begin
                g_addr[ng] = bus_if.mem_addr; g_we[ng] = bus_if.mem_we; g_wdata[ng] = bus_if.mem_wdata;
                ng++;
            end
            prev_req = bus_if.mem_req;
        end
        check("t2_grants", ng, 4);
        wait_ready(0, 20, lat, seen);
        check("t2_last_ready", seen, 1'b1);
        if_ce = 0; d_ce = 0; tick();
        check("t2_g0_addr", g_addr[0], 32'h40);
        check("t2_g0_we", g_we[0], 1'b1);
        check("t2_g0_wdata", g_wdata[0], 32'hDEAD_BEEF);
        check("t2_g1_addr", g_addr[1], 32'h100);
        check("t2_g1_we", g_we[1], 1'b0);
        check("t2_g2_addr", g_addr[2], 32'h40);
        check("t2_g3_addr", g_addr[3], 32'h100);

        // T4: reset in the third D access cycle, then a late ack
        ack_delay = -1;
        d_we = 0; d_addr = 32'h90; d_ce = 1;
        lat = 0;
        while (!bus_if.mem_req && lat < 10) begin tick(); lat++; end
        check("t4_granted", bus_if.mem_req, 1'b1);
        tick(); tick();
        rst = 1; d_ce = 0;
        tick();
        check("t4_mem_req", bus_if.mem_req, 1'b0);
        check("t4_mem_addr", bus_if.mem_addr, 32'h0);
        check("t4_mem_sel", bus_if.mem_sel, 4'h0);
        check("t4_mem_wdata", bus_if.mem_wdata, 32'h0);
        check("t4_if_inst", if_inst, 32'h0);
        check("t4_d_rdata", d_rdata, 32'h0);
        rst = 0; late_req++;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rdy_cnt += int'(if_ready) + int'(d_ready) + int'(bus_err);
        end
        check("t4_late_ack_ignored", rdy_cnt, 0);

        // T3: minimum-latency load
        ack_delay = 0; ack_rdata = 32'hCAFE_F00D;
        d_ce = 1; d_we = 0; d_addr = 32'h84; d_sel = 4'hF;
        wait_ready(1, 20, lat, seen);
        check("t3_seen", seen, 1'b1);
        check("t3_latency", lat, 2);
        check("t3_rdata", d_rdata, 32'hCAFE_F00D);
        d_ce = 0; tick();

        // T5: load never acknowledged -> timeout abort
        ack_delay = -1;
        d_ce = 1; d_we = 0; d_addr = 32'h80;
        seen = 0; lat = 0; hi = 0; err_at_rdy = 0; rd_at_rdy = 32'hFFFF_FFFF;
        while (!seen && lat < 40) begin
            tick(); lat++;
            if (bus_if.mem_req) hi++;
            if (d_ready) begin seen = 1; err_at_rdy = bus_err; rd_at_rdy = d_rdata; end
        end
        check("t5_seen", seen, 1'b1);
        check("t5_req_cycles", hi, 15);
        check("t5_bus_err", err_at_rdy, 1'b1);
        check("t5_rdata_zero", rd_at_rdy, 32'h0);
        d_ce = 0; tick();

        // T6: fetch abandoned one cycle after grant
        ack_delay = 0; ack_rdata = 32'h1111_2222;
        if_ce = 1; if_addr = 32'h200;
        wait_ready(0, 20, lat, seen);
        check("t6_first_inst", if_inst, T6_INST);
        if_ce = 0; tick();
        ack_delay = 3; ack_rdata = 32'h1234_5678;
        if_ce = 1; if_addr = 32'h204;
        lat = 0;
        while (!bus_if.mem_req && lat < 10) begin tick(); lat++; end
        if_ce = 0;
        rdy_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rdy_cnt += int'(if_ready);
            err_cnt += int'(bus_err);
        end
        check("t6_no_ready", rdy_cnt, 0);
        check("t6_no_err", err_cnt, 0);
        check("t6_inst_kept", if_inst, T6_INST);
        check("t6_bus_idle", bus_if.mem_req, 1'b0);

        // T7: same word fetched and loaded
        ack_delay = 1; ack_rdata = 32'h0011_0134;
        if_ce = 1; if_addr = 32'h300;
        wait_ready(0, 20, lat, seen);
        check("t7_inst", if_inst, T7_INST);
        if_ce = 0; tick();
        d_ce = 1; d_we = 0; d_addr = 32'h300;
        wait_ready(1, 20, lat, seen);
        check("t7_load", d_rdata, 32'h0011_0134);
        d_ce = 0; tick();

        // Random phase
        rnd_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(399) == 0) rst = 1;
            if (!if_ce) begin
                if ($urandom_range(3) == 0) begin if_ce = 1; if_addr = $urandom; end
            end else if (if_ready) begin
                if_ce = 1'($urandom_range(1)); if_addr = $urandom;
            end else if ($urandom_range(40) == 0) if_ce = 0;
            if (!d_ce) begin
                if ($urandom_range(3) == 0) begin
                    d_ce = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
                    d_sel = 4'($urandom); d_wdata = $urandom;
                end
            end else if (d_ready) begin
                d_ce = 1'($urandom_range(1)); d_we = 1'($urandom_range(1));
                d_addr = $urandom; d_sel = 4'($urandom); d_wdata = $urandom;
            end else if ($urandom_range(40) == 0) d_ce = 0;
        end
        rnd_mode = 0; rst = 0; if_ce = 0; d_ce = 0;
        for (int i = 0; i < 40; i++) tick();
        check("drain_idle", bus_if.mem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores).
- The bus is multi-cycle with a request/acknowledge handshake.
- Sequences one access at a time, returns read data to the granted requester, and raises stall requests toward the pipeline controller until each requester is served.
- Sits between pc_reg/if_id, mem, and the external memory wrapper.

Parameters:
- ADDR_W, 32, address width of both requesters and the bus.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 15, max cycles waiting for mem_ack before aborting; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_ce  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_inst  out  DATA_W  fetched instruction, registered
- if_ready  out  1  one-cycle pulse: if_inst valid
- d_ce  in  1  data request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_sel  in  DATA_W/8  byte enables
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle pulse: data access done
- stallreq  out  1  to ctrl: (if_ce & ~if_ready) | (d_ce & ~d_ready)
- bus_err  out  1  one-cycle pulse on timeout abort
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_sel  out  DATA_W/8  bus byte enables (all ones on fetch)
- mem_wdata  out  DATA_W  bus write data
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
Reset:
- The clk/rst pair matches the rest of the codebase; rst is synchronous and active-high, fixed.
- On rst=1 at a clock edge: state=IDLE; mem_req=0, mem_we=0, mem_addr/mem_sel/mem_wdata=0; if_inst=d_rdata=ZeroWord; if_ready=d_ready=bus_err=0; timeout counter=0; last_grant=IF.
- Reset mid-access drops mem_req the next cycle. Any later mem_ack is ignored while in IDLE.

States:
- IDLE: evaluate requests.
  - Only d_ce -> grant D.
  - Only if_ce -> grant IF.
  - Both asserted -> grant D, unless last_grant==D, in which case grant IF (anti-starvation alternation).
  - On grant, latch addr/we/sel/wdata into mem_* registers, set mem_req=1 the following cycle, and record last_grant.
  - For IF, mem_we=0 and mem_sel=all ones.
- IF_ACC / D_ACC: hold mem_* stable.
  - On mem_ack: capture mem_rdata into if_inst (IF) or d_rdata (D, loads only; stores leave d_rdata unchanged), pulse the matching ready for exactly one cycle, drop mem_req, go to IDLE.
  - The counter increments every cycle in ACC. If it reaches TIMEOUT without ack: drop mem_req, write ZeroWord to the granted result, pulse ready and bus_err together, go to IDLE.

Latency and timing:
- Minimum latency: request seen in IDLE at cycle N, mem_req high at N+1; with ack at N+1, ready pulses at N+2.
- At least one IDLE cycle always separates consecutive accesses.

Boundary rules:
- Requester drops ce mid-access: the bus access still completes (no abort). Result is discarded, no ready pulse, no timeout error.
- mem_ack while in IDLE is ignored.
- Request inputs are sampled only in IDLE; changes during ACC have no effect until the next grant.
- stallreq is combinational from ce and ready only; it deasserts in the same cycle as the ready pulse.

Optional Feature:
- Macro ARB_IF_BSWAP_EN.
- Defined: the IF path captures mem_rdata byte-reversed into if_inst (bits[31:24]<-[7:0], [23:16]<-[15:8], [15:8]<-[23:16], [7:0]<-[31:24]), for little-endian ROM images. Requires DATA_W=32. The data path is unaffected.
- Undefined: if_inst captures mem_rdata unchanged.

Decomposition:
- Reuse shared defines.v constants: ZeroWord, ChipEnable/ChipDisable, RstEnable, InstAddrBus, InstBus.
- Add to defines.v: ArbStateBus (2 bits) and encodings ArbIdle=2'b00, ArbIfAcc=2'b01, ArbDAcc=2'b10.
- No sub-module is needed; the timeout counter and FSM live in one module.

Test Plan:
- if_ce=1, if_addr=0x0000_0010, ack 2 cycles after mem_req, mem_rdata=0x3401_1100 -> mem_addr=0x10, mem_sel=4'hF, if_inst=0x3401_1100, one if_ready pulse, stallreq high until that pulse.
- if_ce and d_ce both held (d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF, d_sel=4'hF), ack after 1 cycle each -> grant order D, IF, D, IF; store drives mem_we=1 and mem_wdata=0xDEAD_BEEF.
- Load d_addr=0x80, mem_ack never arrives -> mem_req drops after 15 cycles, d_rdata=0, d_ready and bus_err pulse in the same cycle.
- rst=1 asserted in D_ACC cycle 3 -> next cycle mem_req=0 and all outputs zero; a late mem_ack produces no ready pulse.
- if_ce dropped one cycle after grant, ack later with 0x1234_5678 -> no if_ready, if_inst keeps its previous value.
- ARB_IF_BSWAP_EN defined, mem_rdata=0x0011_0134 on a fetch -> if_inst=0x3401_1100; a load of the same word returns 0x0011_0134.
